// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit path.
// Slot widths are capped at MAX_WIDTH so word formatting can use a fixed-size vector.
package i2s_pkg;

  localparam int STEREO_MULTIPLIER = 2;
  localparam int MAX_WIDTH         = 32;

  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_e;

  // Places an audio_w-bit sample (zero-extended) at the top of a slot_w-bit word.
  function automatic logic [MAX_WIDTH-1:0] msb_align(input logic [MAX_WIDTH-1:0] sample,
                                                     input int audio_w,
                                                     input int slot_w);
    return sample << (slot_w - audio_w);
  endfunction

endpackage

// File: rtl/i2s_tx_out_sync_fifo.sv
// Single-clock show-ahead FIFO; flags are registered and track the post-update count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_d;
  logic             full_q, empty_q, wr_ok, rd_ok;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  always_comb begin
    wr_ok   = wr_en_i && !full_q;
    rd_ok   = rd_en_i && !empty_q;
    wptr_d  = wptr_q + PTR_W'(wr_ok);
    rptr_d  = rptr_q + PTR_W'(rd_ok);
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= (count_d == PTR_W'(DEPTH));
      empty_q <= (count_d == '0);
      if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = wptr_q - rptr_q;

endmodule

// File: rtl/i2s_tx_out.sv
// I2S master transmitter: FIFO-buffered stereo frames serialised onto BCLK/LRCLK/SDATA.
// All serial outputs change only in the sys_clk cycle where BCLK falls.
module i2s_tx_out
  import i2s_pkg::*;
#(
  parameter int I2S_WIDTH   = 24,
  parameter int AUDIO_WIDTH = 24,
  parameter int BCLK_DIV    = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [AUDIO_WIDTH-1:0] sample_l_in,
  input  logic [AUDIO_WIDTH-1:0] sample_r_in,
  input  logic                   sample_wr_en,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow,
  output logic                   underrun,
  output logic                   frame_pop,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_data
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(I2S_WIDTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // Packages cannot take parameters, so the frame layout lives here.
  typedef struct packed {
    logic [AUDIO_WIDTH-1:0] left;
    logic [AUDIO_WIDTH-1:0] right;
  } stereo_frame_t;

  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic                   bclk_q, bclk_d;
  lr_e                    lrclk_q, lrclk_d;
  logic [SLOT_W-1:0]      slot_bit_q, slot_bit_d;
  logic                   data_q, data_d;
  logic [AUDIO_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                   underrun_q, underrun_d, frame_pop_q, frame_pop_d;
  logic                   overflow_q, overflow_d;
  logic                   fall_tick, slot_wrap, left_start, pop;
  logic [MAX_WIDTH-1:0]   word_l, word_r, word_cur;
  logic [4:0]             bit_idx;
  stereo_frame_t          fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;

  sync_fifo #(
    .WIDTH(STEREO_MULTIPLIER * AUDIO_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .wr_en_i  (sample_wr_en),
    .wr_data_i(fifo_wdata),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // At a slot start the bit sent is the LSB of the word just finished, which is
  // still selected by the old LRCLK, so one word mux serves both cases.
  always_comb begin
    fifo_wdata = '{left: sample_l_in, right: sample_r_in};
    fall_tick  = bclk_q && (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    slot_wrap  = (slot_bit_q == SLOT_W'(I2S_WIDTH - 1));
    left_start = fall_tick && slot_wrap && (lrclk_q == LR_RIGHT);
    pop        = left_start && (fifo_count != '0);
    word_l     = msb_align(MAX_WIDTH'(hold_l_q), AUDIO_WIDTH, I2S_WIDTH);
    word_r     = msb_align(MAX_WIDTH'(hold_r_q), AUDIO_WIDTH, I2S_WIDTH);
    word_cur   = (lrclk_q == LR_LEFT) ? word_l : word_r;
    bit_idx    = slot_wrap ? 5'd0 : 5'(I2S_WIDTH - 1 - int'(slot_bit_q));
  end

  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    slot_bit_d  = slot_bit_q;
    data_d      = data_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    underrun_d  = 1'b0;
    frame_pop_d = 1'b0;
    overflow_d  = sample_wr_en && fifo_full;
    if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
    end
    if (fall_tick) begin
      data_d = word_cur[bit_idx];
      if (slot_wrap) begin
        slot_bit_d = '0;
        lrclk_d    = (lrclk_q == LR_LEFT) ? LR_RIGHT : LR_LEFT;
      end else begin
        slot_bit_d = slot_bit_q + 1'b1;
      end
    end
    if (left_start) begin
      frame_pop_d = pop;
      underrun_d  = !pop;
      hold_l_d    = pop ? fifo_rdata.left  : '0;
      hold_r_d    = pop ? fifo_rdata.right : '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= LR_RIGHT;
      slot_bit_q  <= SLOT_W'(I2S_WIDTH - 1);
      data_q      <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      underrun_q  <= 1'b0;
      frame_pop_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      slot_bit_q  <= slot_bit_d;
      data_q      <= data_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      underrun_q  <= underrun_d;
      frame_pop_q <= frame_pop_d;
      overflow_q  <= overflow_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_data  = data_q;
  assign underrun  = underrun_q;
  assign frame_pop = frame_pop_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2s_tx_out.sv
// Directed self-checking bench for i2s_tx_out: clocking, framing, FIFO flags, padding, reset.
module tb_i2s_tx_out;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [23:0] sampleL = '0, sampleR = '0;
  logic        wrEn = 1'b0;
  logic [15:0] padSampleL = '0, padSampleR = '0;
  logic        padWrEn = 1'b0;

  logic fifoFull, fifoEmpty, overflow, underrun, framePop, i2sBclk, i2sLrclk, i2sData;
  logic padFull, padEmpty, padOverflow, padUnderrun, padPop, padBclk, padLrclk, padData;

  i2s_tx_out dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sample_l_in(sampleL), .sample_r_in(sampleR), .sample_wr_en(wrEn),
    .fifo_full(fifoFull), .fifo_empty(fifoEmpty), .overflow(overflow),
    .underrun(underrun), .frame_pop(framePop),
    .i2s_bclk(i2sBclk), .i2s_lrclk(i2sLrclk), .i2s_data(i2sData)
  );

  i2s_tx_out #(.I2S_WIDTH(24), .AUDIO_WIDTH(16), .BCLK_DIV(2), .FIFO_DEPTH(4)) dutPad (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sample_l_in(padSampleL), .sample_r_in(padSampleR), .sample_wr_en(padWrEn),
    .fifo_full(padFull), .fifo_empty(padEmpty), .overflow(padOverflow),
    .underrun(padUnderrun), .frame_pop(padPop),
    .i2s_bclk(padBclk), .i2s_lrclk(padLrclk), .i2s_data(padData)
  );

  always #5 sys_clk = ~sys_clk;

  int numChecks = 0;
  int numPass   = 0;
  int cyc       = 0;

  // Receiver models: sample on BCLK rise; an LRCLK change marks the LSB of the previous word.
  int          decL[$], decR[$], padDecL[$], padDecR[$];
  logic [31:0] decShift = '0, padShift = '0;
  logic        decPrevWs = 1'b1, padPrevWs = 1'b1;
  logic        decSeen = 1'b0, padSeen = 1'b0;

  always @(posedge i2sBclk or posedge sys_rst) begin : decMain
    logic [31:0] nxt;
    if (sys_rst) begin
      decShift  <= '0;
      decPrevWs <= 1'b1;
      decSeen   <= 1'b0;
      decL.delete();
      decR.delete();
    end else begin
      nxt = {decShift[30:0], i2sData};
      decShift <= nxt;
      if (i2sLrclk != decPrevWs) begin
        if (decSeen) begin
          if (decPrevWs) decR.push_back(int'(nxt & 32'hFFFFFF));
          else           decL.push_back(int'(nxt & 32'hFFFFFF));
        end
        decSeen <= 1'b1;
      end
      decPrevWs <= i2sLrclk;
    end
  end

  always @(posedge padBclk or posedge sys_rst) begin : decPad
    logic [31:0] nxt;
    if (sys_rst) begin
      padShift  <= '0;
      padPrevWs <= 1'b1;
      padSeen   <= 1'b0;
      padDecL.delete();
      padDecR.delete();
    end else begin
      nxt = {padShift[30:0], padData};
      padShift <= nxt;
      if (padLrclk != padPrevWs) begin
        if (padSeen) begin
          if (padPrevWs) padDecR.push_back(int'(nxt & 32'hFFFFFF));
          else           padDecL.push_back(int'(nxt & 32'hFFFFFF));
        end
        padSeen <= 1'b1;
      end
      padPrevWs <= padLrclk;
    end
  end

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual === expected) numPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic int qAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  // Holds reset for two edges and releases it 1 time unit after a rising edge (cycle 0).
  task automatic applyReset();
    sys_rst = 1'b1;
    wrEn    = 1'b0;
    padWrEn = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cyc     = 0;
  endtask

  // Drives one push cycle on either instance, then idles the write enables.
  task automatic applyStimulus(input logic en, input logic [23:0] l, input logic [23:0] r,
                               input logic pEn, input logic [15:0] pl, input logic [15:0] pr);
    wrEn = en; sampleL = l; sampleR = r;
    padWrEn = pEn; padSampleL = pl; padSampleR = pr;
    tick();
    wrEn = 1'b0;
    padWrEn = 1'b0;
  endtask

  task automatic runUntil(input int target);
    while (cyc < target) tick();
  endtask

  // Runs to a cycle while counting pulse events and any high data bit.
  task automatic runCount(input int target, output int nUnder, output int nPop,
                          output int nData, output int firstPop);
    nUnder = 0; nPop = 0; nData = 0; firstPop = -1;
    while (cyc < target) begin
      tick();
      if (underrun) nUnder++;
      if (i2sData) nData++;
      if (framePop) begin
        if (firstPop < 0) firstPop = cyc;
        nPop++;
      end
    end
  endtask

  logic [23:0] ovL [5] = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678, 24'h9ABCDE};

  initial begin
    int nUnder, nPop, nData, firstPop;
    int bRise[$], lrFall[$], emptyAtPop[$];
    logic prevB, prevLr;

    // Reset values
    @(posedge sys_clk);
    #1;
    checkOutput("rst_bclk", 32'(i2sBclk), 32'd0);
    checkOutput("rst_lrclk", 32'(i2sLrclk), 32'd1);
    checkOutput("rst_data", 32'(i2sData), 32'd0);
    checkOutput("rst_flags", {27'd0, fifoEmpty, fifoFull, overflow, underrun, framePop}, 32'b10000);

    // Idle clocking: divider, frame length and underrun cadence
    applyReset();
    prevB = 1'b0; prevLr = 1'b1; nUnder = 0; nData = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (i2sBclk && !prevB) bRise.push_back(cyc);
      if (!i2sLrclk && prevLr) lrFall.push_back(cyc);
      if (underrun) nUnder++;
      if (i2sData) nData++;
      prevB = i2sBclk; prevLr = i2sLrclk;
    end
    checkOutput("bclk_first_rise", qAt(bRise, 0), 2);
    checkOutput("bclk_period", qAt(bRise, 1) - qAt(bRise, 0), 4);
    checkOutput("lrclk_first_fall", qAt(lrFall, 0), 4);
    checkOutput("lrclk_period", qAt(lrFall, 1) - qAt(lrFall, 0), 192);
    checkOutput("idle_underruns", nUnder, 3);
    checkOutput("idle_data_ones", nData, 0);

    // Single frame on both instances (second one checks MSB alignment padding)
    applyReset();
    applyStimulus(1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 16'h8001, 16'h1234);
    checkOutput("single_not_empty", 32'(fifoEmpty), 32'd0);
    runCount(400, nUnder, nPop, nData, firstPop);
    checkOutput("single_pop_cycle", firstPop, 4);
    checkOutput("single_pop_count", nPop, 1);
    checkOutput("single_underruns", nUnder, 2);
    checkOutput("single_left", qAt(decL, 0), 32'hA5A5A5);
    checkOutput("single_right", qAt(decR, 0), 32'h5A5A5A);
    checkOutput("single_next_left", qAt(decL, 1), 0);
    checkOutput("single_next_right", qAt(decR, 1), 0);
    checkOutput("pad_left", qAt(padDecL, 0), 32'h800100);
    checkOutput("pad_right", qAt(padDecR, 0), 32'h123400);

    // Overflow: four pushes fill the FIFO, the fifth is dropped
    applyReset();
    runUntil(9);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ovL[i], ovL[i] ^ 24'hFFFFFF, 1'b0, 16'h0, 16'h0);
      if (i == 3) begin
        checkOutput("ovf_full_after4", 32'(fifoFull), 32'd1);
        checkOutput("ovf_none_after4", 32'(overflow), 32'd0);
      end
    end
    checkOutput("ovf_pulse", 32'(overflow), 32'd1);
    checkOutput("ovf_still_full", 32'(fifoFull), 32'd1);
    tick();
    checkOutput("ovf_pulse_end", 32'(overflow), 32'd0);
    nPop = 0;
    while (cyc < 970) begin
      tick();
      if (framePop) begin
        nPop++;
        emptyAtPop.push_back(int'(fifoEmpty));
      end
    end
    checkOutput("ovf_pop_count", nPop, 4);
    checkOutput("ovf_empty_pop3", qAt(emptyAtPop, 2), 0);
    checkOutput("ovf_empty_pop4", qAt(emptyAtPop, 3), 1);
    checkOutput("ovf_left_words", decL.size(), 5);
    checkOutput("ovf_underrun_left", qAt(decL, 0), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_left%0d", i), qAt(decL, i + 1), 32'(ovL[i]));
      checkOutput($sformatf("ovf_right%0d", i), qAt(decR, i + 1), 32'(ovL[i] ^ 24'hFFFFFF));
    end

    // Push coinciding with a left-slot start, with one frame queued and with none
    applyReset();
    applyStimulus(1'b1, 24'h111111, 24'h0, 1'b0, 16'h0, 16'h0);
    runUntil(9);
    applyStimulus(1'b1, 24'h222222, 24'h0, 1'b0, 16'h0, 16'h0);
    runUntil(195);
    applyStimulus(1'b1, 24'h333333, 24'h0, 1'b0, 16'h0, 16'h0);
    checkOutput("sim1_flags", {27'd0, fifoEmpty, fifoFull, overflow, underrun, framePop}, 32'b00001);
    runUntil(388);
    checkOutput("sim1_pop_next", 32'(framePop), 32'd1);
    checkOutput("sim1_empty_next", 32'(fifoEmpty), 32'd1);
    runUntil(579);
    applyStimulus(1'b1, 24'h444444, 24'h0, 1'b0, 16'h0, 16'h0);
    checkOutput("sim0_flags", {27'd0, fifoEmpty, fifoFull, overflow, underrun, framePop}, 32'b00010);
    runUntil(880);
    checkOutput("sim_left1", qAt(decL, 1), 32'h222222);
    checkOutput("sim_left2", qAt(decL, 2), 32'h333333);
    checkOutput("sim_left3", qAt(decL, 3), 0);
    checkOutput("sim_left4", qAt(decL, 4), 32'h444444);

    // Asynchronous reset in the middle of a right slot with frames queued
    applyReset();
    applyStimulus(1'b1, 24'h0, 24'hFFFFFF, 1'b0, 16'h0, 16'h0);
    runUntil(9);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ovL[i], ovL[i], 1'b0, 16'h0, 16'h0);
    runUntil(142);
    checkOutput("mid_data_before", 32'(i2sData), 32'd1);
    checkOutput("mid_bclk_before", 32'(i2sBclk), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("mid_bclk", 32'(i2sBclk), 32'd0);
    checkOutput("mid_lrclk", 32'(i2sLrclk), 32'd1);
    checkOutput("mid_data", 32'(i2sData), 32'd0);
    checkOutput("mid_empty", 32'(fifoEmpty), 32'd1);
    checkOutput("mid_full", 32'(fifoFull), 32'd0);
    applyReset();
    runCount(400, nUnder, nPop, nData, firstPop);
    checkOutput("post_rst_pops", nPop, 0);
    checkOutput("post_rst_underruns", nUnder, 3);
    checkOutput("post_rst_data_ones", nData, 0);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
